// File: rtl/mu0_seq_alu.sv
// mu0_seq_alu: registered MU0 ALU with Start/Busy/Done handshake.
// Single-cycle ops finish one clock after Start. Multiply (M=111) runs as
// WIDTH shift-add iterations followed by a one-cycle DONE state.
module mu0_seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_m,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_q,
   output logic             o_z,
   output logic             o_n,
   output logic             o_c
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t             r_state, w_next;
   logic [2*WIDTH-1:0] r_mcand, r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_q;
   logic               r_z, r_n, r_c, r_done;

   logic               w_busy, w_accept_op, w_accept_mul, w_last;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_cout;

   // State register; reset aborts any multiply in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state: only IDLE accepts Start, DONE always returns to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept_mul) w_next = S_MUL;
         S_MUL:   if (w_last)       w_next = S_DONE;
         S_DONE:                    w_next = S_IDLE;
         default:                   w_next = S_IDLE;
      endcase
   end

   // State-decoded controls; Start is ignored outside IDLE.
   always_comb begin
      w_busy       = (r_state == S_MUL);
      w_accept_op  = (r_state == S_IDLE) && i_start && (i_m != 3'b111);
      w_accept_mul = (r_state == S_IDLE) && i_start && (i_m == 3'b111);
      w_last       = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
   end

   // Single-cycle result and carry; subtract is X + ~Y + 1 so C=1 means no borrow.
   always_comb begin
      w_sum  = '0;
      w_res  = '0;
      w_cout = 1'b0;
      case (i_m)
         3'b000: w_res = i_y;
         3'b001: begin
            w_sum  = {1'b0, i_x} + {1'b0, i_y};
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
         end
         3'b010: begin
            w_sum  = {1'b0, i_x} + {{WIDTH{1'b0}}, 1'b1};
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
         end
         3'b011: begin
            w_sum  = {1'b0, i_x} + {1'b0, ~i_y} + {{WIDTH{1'b0}}, 1'b1};
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
         end
         3'b100: w_res = i_x & i_y;
         3'b101: w_res = i_x | i_y;
         3'b110: w_res = i_x ^ i_y;
         default: w_res = '0;
      endcase
   end

   // Shift-add multiplier: operands latched once at Start, then one bit per clock.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_accept_mul) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_x};
         r_mplier <= i_y;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_busy) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   // Result/flag registers; Done pulses exactly when Q and flags change.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q    <= '0;
         r_z    <= 1'b1;
         r_n    <= 1'b0;
         r_c    <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept_op) begin
            r_q    <= w_res;
            r_z    <= (w_res == '0);
            r_n    <= w_res[WIDTH-1];
            r_c    <= w_cout;
            r_done <= 1'b1;
         end else if (r_state == S_DONE) begin
            r_q    <= r_acc[WIDTH-1:0];
            r_z    <= (r_acc[WIDTH-1:0] == '0);
            r_n    <= r_acc[WIDTH-1];
            r_c    <= |r_acc[2*WIDTH-1:WIDTH];
            r_done <= 1'b1;
         end
      end
   end

   assign o_busy = w_busy;
   assign o_done = r_done;
   assign o_q    = r_q;
   assign o_z    = r_z;
   assign o_n    = r_n;
   assign o_c    = r_c;

endmodule

// File: tb/tb_mu0_seq_alu.sv
// tb_mu0_seq_alu: directed vector table for single-cycle ops on a 16-bit
// instance, hand-written multiply/reset sequences on 16- and 8-bit instances.
module tb_mu0_seq_alu;

   logic        clk, rst;
   logic        st16, st8;
   logic [2:0]  m16, m8;
   logic [15:0] x16, y16;
   logic [7:0]  x8, y8;
   logic        busy16, done16, z16, n16, c16;
   logic        busy8, done8, z8, n8, c8;
   logic [15:0] q16;
   logic [7:0]  q8;

   int n_chk = 0;
   int n_fail = 0;

   mu0_seq_alu #(.WIDTH(16)) u_dut16 (
      .i_clk(clk), .i_reset(rst), .i_start(st16), .i_m(m16), .i_x(x16), .i_y(y16),
      .o_busy(busy16), .o_done(done16), .o_q(q16), .o_z(z16), .o_n(n16), .o_c(c16));

   mu0_seq_alu #(.WIDTH(8)) u_dut8 (
      .i_clk(clk), .i_reset(rst), .i_start(st8), .i_m(m8), .i_x(x8), .i_y(y8),
      .o_busy(busy8), .o_done(done8), .o_q(q8), .o_z(z8), .o_n(n8), .o_c(c8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  m;
      logic [15:0] x, y, q;
      logic        c, z, n;
   } vec_t;

   vec_t vt[11];

   task automatic apply(input int i);
      st16 = 1'b1; m16 = vt[i].m; x16 = vt[i].x; y16 = vt[i].y;
   endtask

   // Run one multiply on the chosen instance (sel=1 -> 8-bit), with optional
   // Start noise while busy and in the DONE cycle.
   task automatic mul_run(input bit sel, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] eq, input bit ec, input int w, input bit noise);
      logic [15:0] q; logic b, d, z, n, c;
      int lat, bcnt; bit got;
      @(negedge clk);
      if (sel) begin st8 = 1'b1; m8 = 3'b111; x8 = x[7:0]; y8 = y[7:0]; end
      else     begin st16 = 1'b1; m16 = 3'b111; x16 = x; y16 = y; end
      lat = 0; bcnt = 0; got = 1'b0;
      for (int i = 1; i <= 60 && !got; i++) begin
         @(negedge clk);
         q = sel ? {8'h00, q8} : q16;
         b = sel ? busy8 : busy16;  d = sel ? done8 : done16;
         z = sel ? z8 : z16;  n = sel ? n8 : n16;  c = sel ? c8 : c16;
         if (b) bcnt++;
         if (b && d) chk("busy_and_done", 1, 0);
         if (d) begin
            got = 1'b1; lat = i - 1;
            chk("mul_q", q, eq);
            chk("mul_c", c, ec);
            chk("mul_z", z, (eq == 16'h0));
            chk("mul_n", n, sel ? eq[7] : eq[15]);
         end
         // noise: alternate add and multiply requests with junk operands
         if (noise && !d) begin
            if (sel) begin st8 = 1'b1; m8 = i[0] ? 3'b111 : 3'b001; x8 = 8'hA5; y8 = 8'h5A; end
            else     begin st16 = 1'b1; m16 = i[0] ? 3'b111 : 3'b001; x16 = 16'hAAAA; y16 = 16'h5555; end
         end else begin
            st8 = 1'b0; st16 = 1'b0;
         end
      end
      chk("mul_done_seen", got, 1);
      chk("mul_latency", lat, w + 1);
      chk("mul_busy_cycles", bcnt, w);
      @(negedge clk);
      chk("mul_done_one_pulse", sel ? done8 : done16, 0);
      chk("mul_idle_after", sel ? busy8 : busy16, 0);
   endtask

   initial begin
      int ndone;
      vt[0]  = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
      vt[1]  = '{3'b011, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1};
      vt[2]  = '{3'b011, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{3'b100, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1};
      vt[4]  = '{3'b000, 16'hABCD, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{3'b010, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1};
      vt[6]  = '{3'b101, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{3'b110, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{3'b010, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{3'b001, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
      vt[10] = '{3'b011, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0};

      rst = 1'b1; st16 = 1'b0; st8 = 1'b0; m16 = '0; m8 = '0;
      x16 = '0; y16 = '0; x8 = '0; y8 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_q16", q16, 0);     chk("rst_z16", z16, 1);
      chk("rst_n16", n16, 0);     chk("rst_c16", c16, 0);
      chk("rst_busy16", busy16, 0); chk("rst_done16", done16, 0);
      chk("rst_q8", q8, 0);       chk("rst_z8", z8, 1);

      // back-to-back single-cycle ops: one Done per Start
      @(negedge clk);
      apply(0);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_done", i), done16, 1);
         chk($sformatf("v%0d_busy", i), busy16, 0);
         chk($sformatf("v%0d_q", i), q16, vt[i].q);
         chk($sformatf("v%0d_c", i), c16, vt[i].c);
         chk($sformatf("v%0d_z", i), z16, vt[i].z);
         chk($sformatf("v%0d_n", i), n16, vt[i].n);
         if (i + 1 < 11) apply(i + 1);
         else st16 = 1'b0;
      end
      @(negedge clk);
      chk("op_done_drop", done16, 0);
      chk("op_q_hold", q16, 16'h7FFF);

      // multiplies, 16-bit
      mul_run(1'b0, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 16, 1'b0);
      mul_run(1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 16, 1'b1);
      mul_run(1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 16, 1'b1);

      // reset mid-multiply aborts without Done
      @(negedge clk);
      st16 = 1'b1; m16 = 3'b111; x16 = 16'h1234; y16 = 16'h5678;
      @(negedge clk);
      st16 = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_before_rst", busy16, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy16, 0); chk("abort_done", done16, 0);
      chk("abort_q", q16, 0);       chk("abort_z", z16, 1);
      chk("abort_n", n16, 0);       chk("abort_c", c16, 0);
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done16 || busy16) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      mul_run(1'b0, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 16, 1'b0);

      // reset and start together: start dropped
      @(negedge clk);
      rst = 1'b1; st16 = 1'b1; m16 = 3'b001; x16 = 16'h0001; y16 = 16'h0001;
      @(negedge clk);
      rst = 1'b0; st16 = 1'b0;
      chk("rst_start_done", done16, 0);
      chk("rst_start_q", q16, 0);
      @(negedge clk);
      chk("rst_start_dropped", done16, 0);
      chk("rst_start_busy", busy16, 0);

      // 8-bit instance
      mul_run(1'b1, 16'h000F, 16'h0011, 16'h00FF, 1'b0, 8, 1'b0);
      mul_run(1'b1, 16'h00FF, 16'h00FF, 16'h0001, 1'b1, 8, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
